y86_alu: RTL and testbench
==========================

Y86_ALU -- requirements
Module: y86_alu

Interface
REQ-001 Parameter: W, 64, datapath width in bits.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset; one clock, asynchronous active-low reset.
REQ-004 alu_a  input  W  operand A.
REQ-005 alu_b  input  W  operand B.
REQ-006 alu_fun  input  4  operation select.
REQ-007 set_cc  input  1  capture condition codes from current result at next rising edge.
REQ-008 cond_fun  input  4  condition select for cond output.
REQ-009 alu_out  output  W  combinational result.
REQ-010 cc  output  3  registered flags {ZF,SF,OF} (bit2=ZF, bit1=SF, bit0=OF).
REQ-011 cond  output  1  combinational condition evaluated from registered cc.
REQ-012 fun_err  output  1  combinational; high when alu_fun is not a supported operation.

Function
REQ-013 alu_out SHALL be combinational, zero latency: fun 0 = A+B, 1 = A-B, 2 = A&B, 3 = A^B; W-bit result, carry/borrow discarded (modulo 2^W wrap).
REQ-014 Unsupported alu_fun SHALL give alu_out = 0 and fun_err = 1; supported fun gives fun_err = 0.
REQ-015 Next-flag values: ZF = (alu_out == 0); SF = alu_out[W-1].
REQ-016 OF for add SHALL be 1 iff A[W-1] == B[W-1] and alu_out[W-1] != A[W-1].
REQ-017 OF for sub SHALL be 1 iff A[W-1] != B[W-1] and alu_out[W-1] != A[W-1].
REQ-018 OF for logical ops and unsupported fun SHALL be 0.
REQ-019 cc SHALL load all three next-flag values on a rising clk edge when set_cc = 1, and hold otherwise; no partial updates.
REQ-020 cond SHALL use the registered cc, not the next-flag values; a set_cc in the same cycle affects cond only after the edge.
REQ-021 cond_fun: 0 = 1 (always); 1 le = (SF^OF)|ZF; 2 l = SF^OF; 3 e = ZF; 4 ne = ~ZF; 5 ge = ~(SF^OF); 6 g = ~(SF^OF)&~ZF; 7..15 = 0.

Reset
REQ-022 rst_n low SHALL clear cc to 3'b000 immediately, independent of clk.
REQ-023 While rst_n is low, cc SHALL ignore set_cc.
REQ-024 After rst_n goes low, cond SHALL equal its value for cc = 000 (fun 0 gives 1, fun 4 gives 1, fun 5 gives 1, fun 3 gives 0).
REQ-025 alu_out and fun_err are combinational; reset SHALL not affect them.
REQ-026 Deassertion of rst_n SHALL take effect on the next rising clk edge; no flag update occurs at that edge unless set_cc = 1.

Configuration
REQ-027 Macro Y86_ALU_EXT_OPS_EN, when defined: fun 4 = A|B, 5 = A<<B[5:0] (logical), 6 = A>>B[5:0] (logical); each sets fun_err = 0 and OF = 0.
REQ-028 Without Y86_ALU_EXT_OPS_EN, fun 4..15 SHALL all be unsupported as in REQ-014.

Structure
REQ-029 Shared package y86_alu_pkg SHALL hold the operation codes (ADD=0, SUB=1, AND=2, XOR=3, OR=4, SHL=5, SHR=6).
REQ-030 The package SHALL also hold the condition codes (ALWAYS=0 through G=6) and the cc bit indices ZF=2, SF=1, OF=0.
REQ-031 One sub-module, y86_cond_eval, SHALL map cc and cond_fun to cond (purely combinational).
REQ-032 The arithmetic and logic datapath and the cc register SHALL remain in y86_alu.

Verification
REQ-033 Add overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1, fun 0, set_cc -> alu_out=0x8000_0000_0000_0000; after the edge cc=011 (SF=1, OF=1); cond_fun 2 gives 0.
REQ-034 Subtract to zero: A=5, B=5, fun 1, set_cc -> alu_out=0, cc=100; cond_fun 3 gives 1, cond_fun 1 gives 1, cond_fun 6 gives 0.
REQ-035 Subtract negative, no overflow: A=3, B=5, fun 1 -> alu_out=0xFFFF_FFFF_FFFF_FFFE, cc=010; cond_fun 2 gives 1, cond_fun 5 gives 0.
REQ-036 Hold and reset: set_cc=0 with fun 3 (A=B=0xF0) -> cc unchanged; then pulse rst_n low between clk edges -> cc=000 immediately.
REQ-037 Logic and unsupported ops: fun 2 with A=0xFF00, B=0x0FF0 -> 0x0F00, fun_err=0; fun 9 -> alu_out=0, fun_err=1, OF=0.
REQ-038 Config-dependent fun 4: with macro, A=0x0F, B=0xF0 -> 0xFF and fun_err=0; without macro -> alu_out=0 and fun_err=1.

Source files
------------

// File: rtl/y86_alu_pkg.sv
// Shared definitions for the Y86 ALU: operation codes, condition codes,
// cc bit positions and signed-overflow helpers.
package y86_alu_pkg;

  // ALU operation select
  typedef enum logic [3:0] {
    AluAdd = 4'd0,
    AluSub = 4'd1,
    AluAnd = 4'd2,
    AluXor = 4'd3,
    AluOr  = 4'd4,
    AluShl = 4'd5,
    AluShr = 4'd6
  } alu_fun_e;

  // Condition select for the cond output
  typedef enum logic [3:0] {
    CondAlways = 4'd0,
    CondLe     = 4'd1,
    CondL      = 4'd2,
    CondE      = 4'd3,
    CondNe     = 4'd4,
    CondGe     = 4'd5,
    CondG      = 4'd6
  } cond_fun_e;

  // Bit positions inside the 3-bit cc vector
  localparam int unsigned CcZf = 2;
  localparam int unsigned CcSf = 1;
  localparam int unsigned CcOf = 0;

  // Signed overflow of a+b from operand and result sign bits
  function automatic logic add_of(input logic a_s, input logic b_s, input logic r_s);
    return (a_s == b_s) && (r_s != a_s);
  endfunction

  // Signed overflow of a-b from operand and result sign bits
  function automatic logic sub_of(input logic a_s, input logic b_s, input logic r_s);
    return (a_s != b_s) && (r_s != a_s);
  endfunction

endpackage

// File: rtl/y86_alu_if.sv
// Operand/result bundle of the Y86 ALU. The master drives operands and
// selects; the slave (the ALU) returns result, flags, condition and error.
interface y86_alu_if #(
  parameter int unsigned W = 64
);
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [3:0]   alu_fun;
  logic         set_cc;
  logic [3:0]   cond_fun;
  logic [W-1:0] alu_out;
  logic [2:0]   cc;
  logic         cond;
  logic         fun_err;

  modport master (
    output alu_a, alu_b, alu_fun, set_cc, cond_fun,
    input  alu_out, cc, cond, fun_err
  );

  modport slave (
    input  alu_a, alu_b, alu_fun, set_cc, cond_fun,
    output alu_out, cc, cond, fun_err
  );
endinterface

// File: rtl/y86_cond_eval.sv
// Purely combinational mapping of registered flags {ZF,SF,OF} and a
// condition select to the branch/move condition.
module y86_cond_eval
  import y86_alu_pkg::*;
(
  input  logic [2:0] cc_i,
  input  logic [3:0] cond_fun_i,
  output logic       cond_o
);

  logic zf, sf, of, lt;

  assign zf = cc_i[CcZf];
  assign sf = cc_i[CcSf];
  assign of = cc_i[CcOf];
  assign lt = sf ^ of;

  // Decode the condition select; undefined selects evaluate false
  always_comb begin
    cond_o = 1'b0;
    case (cond_fun_i)
      CondAlways: cond_o = 1'b1;
      CondLe:     cond_o = lt | zf;
      CondL:      cond_o = lt;
      CondE:      cond_o = zf;
      CondNe:     cond_o = ~zf;
      CondGe:     cond_o = ~lt;
      CondG:      cond_o = ~lt & ~zf;
      default:    cond_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/y86_alu.sv
// Y86 ALU: combinational add/sub/and/xor datapath with a condition-code
// register and a condition evaluator on the registered flags.
// Build option: define Y86_ALU_EXT_OPS_EN to add OR, SHL and SHR (fun 4..6).
module y86_alu
  import y86_alu_pkg::*;
#(
  parameter int unsigned W = 64
) (
  input  logic     clk,
  input  logic     rst_n,
  y86_alu_if.slave bus
);

  logic [W-1:0] alu_res;
  logic         fun_err;
  logic         of_next;
  logic [2:0]   cc_d;
  logic [2:0]   cc_q;
  logic [W-1:0] sum;
  logic [W-1:0] diff;

  // Carry/borrow out is deliberately dropped: results wrap modulo 2^W
  assign sum  = bus.alu_a + bus.alu_b;
  assign diff = bus.alu_a - bus.alu_b;

  // Operation decode; unsupported selects give a zero result and no overflow
  always_comb begin
    alu_res = '0;
    fun_err = 1'b1;
    of_next = 1'b0;
    case (bus.alu_fun)
      AluAdd: begin
        alu_res = sum;
        fun_err = 1'b0;
        of_next = add_of(bus.alu_a[W-1], bus.alu_b[W-1], sum[W-1]);
      end
      AluSub: begin
        alu_res = diff;
        fun_err = 1'b0;
        of_next = sub_of(bus.alu_a[W-1], bus.alu_b[W-1], diff[W-1]);
      end
      AluAnd: begin
        alu_res = bus.alu_a & bus.alu_b;
        fun_err = 1'b0;
      end
      AluXor: begin
        alu_res = bus.alu_a ^ bus.alu_b;
        fun_err = 1'b0;
      end
`ifdef Y86_ALU_EXT_OPS_EN
      AluOr: begin
        alu_res = bus.alu_a | bus.alu_b;
        fun_err = 1'b0;
      end
      AluShl: begin
        alu_res = bus.alu_a << bus.alu_b[5:0];
        fun_err = 1'b0;
      end
      AluShr: begin
        alu_res = bus.alu_a >> bus.alu_b[5:0];
        fun_err = 1'b0;
      end
`endif
      default: begin
        alu_res = '0;
        fun_err = 1'b1;
        of_next = 1'b0;
      end
    endcase
  end

  // Next-flag values derived from the current result
  always_comb begin
    cc_d       = 3'b000;
    cc_d[CcZf] = ~|alu_res;
    cc_d[CcSf] = alu_res[W-1];
    cc_d[CcOf] = of_next;
  end

  // Condition-code register: all three flags load together on set_cc
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q <= 3'b000;
    end else if (bus.set_cc) begin
      cc_q <= cc_d;
    end
  end

  y86_cond_eval u_cond_eval (
    .cc_i       (cc_q),
    .cond_fun_i (bus.cond_fun),
    .cond_o     (bus.cond)
  );

  assign bus.alu_out = alu_res;
  assign bus.fun_err = fun_err;
  assign bus.cc      = cc_q;

endmodule

// File: tb/tb_y86_alu.sv
// Scoreboard bench for y86_alu: a stimulus process drives one directed
// vector per clock and queues its hand-computed expectation; a monitor
// pops and compares on the falling edge.
module tb_y86_alu;

  localparam int unsigned W = 64;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   fun;
    logic         set_cc;
    logic [3:0]   cf;
    logic         rst;
    logic [W-1:0] eo;
    logic         ee;
    logic [2:0]   ecc;
    logic         ec;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;
  vec_t vecs[$];
  vec_t exp_q[$];

  y86_alu_if #(.W(W)) bus ();

  y86_alu #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] fun,
                     input logic set_cc, input logic [3:0] cf, input logic rst,
                     input logic [W-1:0] eo, input logic ee, input logic [2:0] ecc,
                     input logic ec);
    vec_t v;
    v.a = a; v.b = b; v.fun = fun; v.set_cc = set_cc; v.cf = cf; v.rst = rst;
    v.eo = eo; v.ee = ee; v.ecc = ecc; v.ec = ec;
    vecs.push_back(v);
  endtask

  // Monitor: compare every queued expectation away from the rising edge
  initial begin
    vec_t e;
    bit   bad;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        bad = 1'b0;
        if (bus.alu_out !== e.eo) begin
          $display("FAIL v%0d alu_out got %h want %h", n_vec, bus.alu_out, e.eo);
          bad = 1'b1;
        end
        if (bus.fun_err !== e.ee) begin
          $display("FAIL v%0d fun_err got %b want %b", n_vec, bus.fun_err, e.ee);
          bad = 1'b1;
        end
        if (bus.cc !== e.ecc) begin
          $display("FAIL v%0d cc got %b want %b", n_vec, bus.cc, e.ecc);
          bad = 1'b1;
        end
        if (bus.cond !== e.ec) begin
          $display("FAIL v%0d cond got %b want %b", n_vec, bus.cond, e.ec);
          bad = 1'b1;
        end
        n_vec++;
        if (bad) n_miss++;
      end
    end
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout bench did not finish");
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b0;
    bus.alu_a    = '0;
    bus.alu_b    = '0;
    bus.alu_fun  = 4'd0;
    bus.set_cc   = 1'b0;
    bus.cond_fun = 4'd0;

    // Held in reset: set_cc ignored, cond reflects cc=000
    add(64'd5, 64'd5, 4'd1, 1'b1, 4'd0, 1'b1, 64'd0, 1'b0, 3'b000, 1'b1);
    add(64'd5, 64'd5, 4'd1, 1'b1, 4'd4, 1'b1, 64'd0, 1'b0, 3'b000, 1'b1);
    add(64'd5, 64'd5, 4'd1, 1'b1, 4'd5, 1'b1, 64'd0, 1'b0, 3'b000, 1'b1);
    add(64'd5, 64'd5, 4'd1, 1'b1, 4'd3, 1'b1, 64'd0, 1'b0, 3'b000, 1'b0);
    // Add overflow -> cc 011
    add(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'd0, 1'b1, 4'd2, 1'b0,
        64'h8000_0000_0000_0000, 1'b0, 3'b000, 1'b0);
    add(64'd0, 64'd0, 4'd2, 1'b0, 4'd2, 1'b0, 64'd0, 1'b0, 3'b011, 1'b0);
    add(64'd0, 64'd0, 4'd2, 1'b0, 4'd1, 1'b0, 64'd0, 1'b0, 3'b011, 1'b0);
    // Subtract to zero -> cc 100
    add(64'd5, 64'd5, 4'd1, 1'b1, 4'd3, 1'b0, 64'd0, 1'b0, 3'b011, 1'b0);
    // Hold with xor, set_cc low
    add(64'hF0, 64'hF0, 4'd3, 1'b0, 4'd3, 1'b0, 64'd0, 1'b0, 3'b100, 1'b1);
    add(64'hF0, 64'hF0, 4'd3, 1'b0, 4'd1, 1'b0, 64'd0, 1'b0, 3'b100, 1'b1);
    add(64'hF0, 64'hF0, 4'd3, 1'b0, 4'd6, 1'b0, 64'd0, 1'b0, 3'b100, 1'b0);
    // Subtract negative, no overflow -> cc 010
    add(64'd3, 64'd5, 4'd1, 1'b1, 4'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 3'b100, 1'b0);
    add(64'hFF00, 64'h0FF0, 4'd2, 1'b0, 4'd2, 1'b0, 64'h0F00, 1'b0, 3'b010, 1'b1);
    add(64'hFF00, 64'h0FF0, 4'd2, 1'b0, 4'd5, 1'b0, 64'h0F00, 1'b0, 3'b010, 1'b0);
    // Unsupported fun 9 captured -> cc 100 (OF clear)
    add(64'hFF, 64'd1, 4'd9, 1'b1, 4'd0, 1'b0, 64'd0, 1'b1, 3'b010, 1'b1);
    add(64'hF0, 64'hF0, 4'd3, 1'b0, 4'd3, 1'b0, 64'd0, 1'b0, 3'b100, 1'b1);
    // Mid-cycle reset pulse clears cc at once
    add(64'hF0, 64'hF0, 4'd3, 1'b0, 4'd3, 1'b1, 64'd0, 1'b0, 3'b000, 1'b0);
`ifdef Y86_ALU_EXT_OPS_EN
    add(64'h0F, 64'hF0, 4'd4, 1'b1, 4'd0, 1'b0, 64'hFF, 1'b0, 3'b000, 1'b1);
    add(64'd1, 64'd1, 4'd0, 1'b0, 4'd3, 1'b0, 64'd2, 1'b0, 3'b000, 1'b0);
    add(64'h8000_0000_0000_0000, 64'd1, 4'd1, 1'b1, 4'd0, 1'b0,
        64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 3'b000, 1'b1);
`else
    add(64'h0F, 64'hF0, 4'd4, 1'b1, 4'd0, 1'b0, 64'd0, 1'b1, 3'b000, 1'b1);
    add(64'd1, 64'd1, 4'd0, 1'b0, 4'd3, 1'b0, 64'd2, 1'b0, 3'b100, 1'b1);
    add(64'h8000_0000_0000_0000, 64'd1, 4'd1, 1'b1, 4'd0, 1'b0,
        64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 3'b100, 1'b1);
`endif
    // Subtract overflow captured -> cc 001; xor negative -> cc 010
    add(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 4'd3, 1'b1, 4'd2, 1'b0,
        64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'b001, 1'b1);
    add(64'd0, 64'd0, 4'd0, 1'b0, 4'd4, 1'b0, 64'd0, 1'b0, 3'b010, 1'b1);
    // Add with carry-out wraps to zero, no overflow -> cc 100
    add(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd0, 1'b1, 4'd5, 1'b0, 64'd0, 1'b0, 3'b010, 1'b0);
`ifdef Y86_ALU_EXT_OPS_EN
    add(64'd1, 64'd4, 4'd5, 1'b0, 4'd7, 1'b0, 64'h10, 1'b0, 3'b100, 1'b0);
    add(64'h80, 64'h43, 4'd6, 1'b0, 4'd15, 1'b0, 64'h10, 1'b0, 3'b100, 1'b0);
`else
    add(64'd1, 64'd4, 4'd5, 1'b0, 4'd7, 1'b0, 64'd0, 1'b1, 3'b100, 1'b0);
    add(64'h80, 64'h43, 4'd6, 1'b0, 4'd15, 1'b0, 64'd0, 1'b1, 3'b100, 1'b0);
`endif
    add(64'd0, 64'd0, 4'd0, 1'b0, 4'd3, 1'b0, 64'd0, 1'b0, 3'b100, 1'b1);

    repeat (2) @(posedge clk);
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst_n        = ~vecs[i].rst;
      bus.alu_a    = vecs[i].a;
      bus.alu_b    = vecs[i].b;
      bus.alu_fun  = vecs[i].fun;
      bus.set_cc   = vecs[i].set_cc;
      bus.cond_fun = vecs[i].cf;
      exp_q.push_back(vecs[i]);
    end

    // Drain the scoreboard within a bounded number of cycles
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      $display("FAIL drain %0d expectations left want 0", exp_q.size());
      n_miss++;
    end
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
